lfsr_random_v3: RTL and testbench

//  Parametrised hole/target picker for the PunchZombi game. A free-running Galois LFSR supplies

---
 rtl/pz_rand_pkg.sv | 35 +++
 rtl/pz_lfsr_core.sv | 19 +
 rtl/lfsr_random_v3.sv | 64 ++++++
 tb/tb_lfsr_random_v3.sv | 94 +++++++++
 4 files changed

// File: rtl/pz_rand_pkg.sv
// pz_rand_pkg: Galois LFSR tap table and draw FSM state type for the hole picker.
package pz_rand_pkg;
    typedef enum logic {IDLE, DRAW} state_t;
    localparam logic [15:0] TAPS16 = 16'hB400;
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            8:       lfsr_taps = 32'h0000_00B8;
            9:       lfsr_taps = 32'h0000_0110;
            10:      lfsr_taps = 32'h0000_0240;
            11:      lfsr_taps = 32'h0000_0500;
            12:      lfsr_taps = 32'h0000_0829;
            13:      lfsr_taps = 32'h0000_100D;
            14:      lfsr_taps = 32'h0000_2015;
            15:      lfsr_taps = 32'h0000_6000;
            16:      lfsr_taps = {16'h0, TAPS16};
            17:      lfsr_taps = 32'h0001_2000;
            18:      lfsr_taps = 32'h0002_0400;
            19:      lfsr_taps = 32'h0004_0023;
            20:      lfsr_taps = 32'h0009_0000;
            21:      lfsr_taps = 32'h0014_0000;
            22:      lfsr_taps = 32'h0030_0000;
            23:      lfsr_taps = 32'h0042_0000;
            24:      lfsr_taps = 32'h00E1_0000;
            25:      lfsr_taps = 32'h0120_0000;
            26:      lfsr_taps = 32'h0200_0023;
            27:      lfsr_taps = 32'h0400_0013;
            28:      lfsr_taps = 32'h0900_0000;
            29:      lfsr_taps = 32'h1400_0000;
            30:      lfsr_taps = 32'h2000_0029;
            31:      lfsr_taps = 32'h4800_0000;
            32:      lfsr_taps = 32'h8020_0003;
            default: lfsr_taps = 32'h0;
        endcase
    endfunction
endpackage

// File: rtl/pz_lfsr_core.sv
// pz_lfsr_core: free-running right-shift Galois LFSR with seed load; a zero seed becomes 1.
module pz_lfsr_core #(
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS = LFSR_W'(16'hB400),
    parameter logic [LFSR_W-1:0] SEED = LFSR_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);
    localparam logic [LFSR_W-1:0] ONE = LFSR_W'(1);
    localparam logic [LFSR_W-1:0] SEED_FIX = SEED == '0 ? ONE : SEED;
    always_ff @(posedge clk)
        if (rst) q <= SEED_FIX;
        else if (load) q <= load_val == '0 ? ONE : load_val;
        else q <= q[0] ? (q >> 1) ^ TAPS : q >> 1;
endmodule

// File: rtl/lfsr_random_v3.sv
// lfsr_random_v3: rejection-sampling picker of 1..N_HOLES from a free-running LFSR.
// Define PZ_RAND_NO_REPEAT_EN to forbid emitting the same value twice in a row.
module lfsr_random_v3 import pz_rand_pkg::*; #(
    parameter int LFSR_W = 16,
    parameter int N_HOLES = 3,
    parameter int MAX_TRIES = 8,
    parameter logic [LFSR_W-1:0] SEED_RST = LFSR_W'(1),
    localparam int OUT_W = $clog2(N_HOLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              req,
    output logic [OUT_W-1:0]  rand_num,
    output logic              rand_valid,
    output logic              busy
);
    localparam int TW = $clog2(MAX_TRIES) + 1;
    localparam logic [31:0] TAPS_ALL = lfsr_taps(LFSR_W);
    localparam logic [LFSR_W-1:0] TAPS = TAPS_ALL[LFSR_W-1:0];
    localparam logic [LFSR_W-1:0] NHW = LFSR_W'(N_HOLES);
    localparam logic [OUT_W-1:0] NH = OUT_W'(N_HOLES);
    localparam logic [TW-1:0] LAST = TW'(MAX_TRIES - 1);
    logic [LFSR_W-1:0] lfsr;
    logic [OUT_W-1:0] cand, fb, fb_sel;
    logic [TW-1:0] tries;
    logic ok;
    state_t state;
    pz_lfsr_core #(.LFSR_W(LFSR_W), .TAPS(TAPS), .SEED(SEED_RST)) u_lfsr (
        .clk(clk), .rst(rst), .load(seed_load), .load_val(seed), .q(lfsr)
    );
    assign cand = lfsr[OUT_W-1:0];
    assign fb = OUT_W'(lfsr % NHW) + OUT_W'(1);
`ifdef PZ_RAND_NO_REPEAT_EN
    assign ok = cand != '0 && 32'(cand) <= N_HOLES && cand != rand_num;
    assign fb_sel = fb != rand_num ? fb : fb == NH ? OUT_W'(1) : fb + OUT_W'(1);
`else
    assign ok = cand != '0 && 32'(cand) <= N_HOLES;
    assign fb_sel = fb;
`endif
    assign busy = state == DRAW;
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            tries <= '0;
            rand_num <= '0;
            rand_valid <= 1'b0;
        end else begin
            rand_valid <= 1'b0;
            if (state == IDLE) begin
                if (req) begin
                    state <= DRAW;
                    tries <= '0;
                end
            end else if (ok || tries == LAST) begin
                rand_num <= ok ? cand : fb_sel;
                rand_valid <= 1'b1;
                state <= IDLE;
            end else begin
                tries <= tries + TW'(1);
            end
        end
endmodule

// File: tb/tb_lfsr_random_v3.sv
// tb_lfsr_random_v3: directed checks of reset, stepping, accept, fallback and abort paths.
module tb_lfsr_random_v3;
    logic clk = 0, rst = 1, seed_load = 0, req = 0, req16 = 0;
    logic [15:0] seed = 0;
    logic [1:0] rn, rn16;
    logic rv, rv16, busy, busy16;
    int total = 0, passed = 0;
    int lat, val, nv, bz;
`ifdef PZ_RAND_NO_REPEAT_EN
    localparam bit NR = 1;
`else
    localparam bit NR = 0;
`endif
    always #5 clk = ~clk;
    lfsr_random_v3 #(.LFSR_W(16), .N_HOLES(3), .MAX_TRIES(8), .SEED_RST(16'h0001)) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
        .rand_num(rn), .rand_valid(rv), .busy(busy)
    );
    lfsr_random_v3 #(.LFSR_W(16), .N_HOLES(3), .MAX_TRIES(16), .SEED_RST(16'h0001)) dut16 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req16),
        .rand_num(rn16), .rand_valid(rv16), .busy(busy16)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic draw(input bit sel, input logic [15:0] s, input int extra,
                        output int l, output int v, output int n, output int b);
        l = 0; v = -1; n = 0; b = -1;
        @(negedge clk); seed_load = 1; seed = s;
        @(negedge clk); seed_load = 0;
        chk("seed_loaded", 32'(dut.lfsr), s == 0 ? 32'h1 : 32'(s));
        if (sel) req16 = 1; else req = 1;
        @(negedge clk);
        chk("busy_after_req", 32'(sel ? busy16 : busy), 1);
        req16 = 0; req = extra > 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sel ? rv16 : rv) begin
                n++;
                if (l == 0) begin
                    l = i + 2; v = sel ? rn16 : rn; b = sel ? busy16 : busy;
                end
            end
            req = i + 1 < extra;
        end
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rand_num", 32'(rn), 0);
        chk("rst_rand_valid", 32'(rv), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_lfsr", 32'(dut.lfsr), 32'h0001);
        rst = 0;
        @(negedge clk); chk("step1", 32'(dut.lfsr), 32'hB400);
        @(negedge clk); chk("step2", 32'(dut.lfsr), 32'h5A00);
        // immediate accept: 0x0003 -> 0xB401, cand 1
        draw(0, 16'h0003, 0, lat, val, nv, bz);
        chk("accept_lat", lat, 2); chk("accept_val", val, 1);
        chk("accept_pulses", nv, 1); chk("accept_busy", bz, 0);
        chk("accept_hold", 32'(rn), 1);
        // every candidate 00 -> fallback (0x168 % 3) + 1
        draw(0, 16'h0001, 0, lat, val, nv, bz);
        chk("fallback_lat", lat, 9); chk("fallback_val", val, NR ? 2 : 1);
        chk("fallback_pulses", nv, 1); chk("fallback_busy", bz, 0);
        draw(1, 16'h0001, 0, lat, val, nv, bz);
        chk("tries16_lat", lat, 11); chk("tries16_val", val, 2);
        chk("tries16_pulses", nv, 1);
        // zero seed coerced, reqs while busy ignored
        draw(0, 16'h0000, 3, lat, val, nv, bz);
        chk("busyreq_lat", lat, 9); chk("busyreq_val", val, 1);
        chk("busyreq_pulses", nv, 1);
        draw(0, 16'h0003, 0, lat, val, nv, bz);
        chk("repeat_lat", lat, NR ? 9 : 2); chk("repeat_val", val, NR ? 2 : 1);
        chk("repeat_pulses", nv, 1);
        // reset in the middle of a long draw
        @(negedge clk); seed_load = 1; seed = 16'h0001;
        @(negedge clk); seed_load = 0; req = 1;
        @(negedge clk); req = 0; chk("abort_busy_pre", 32'(busy), 1);
        @(negedge clk); rst = 1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0); chk("abort_valid", 32'(rv), 0);
        chk("abort_rand_num", 32'(rn), 0); chk("abort_lfsr", 32'(dut.lfsr), 32'h0001);
        rst = 0; nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (rv) nv++;
        end
        chk("abort_no_valid", nv, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
